// File: rtl/sram_block_controller.sv
// Clocked 68000-to-SRAM block controller: latches a CPU cycle, decodes a one-hot
// block select, times the SRAM strobes with a fixed wait-state count and returns Dtack_L.
module sram_block_controller #(
  parameter int ADDR_WIDTH  = 17,
  parameter int NUM_BLOCKS  = 4,
  parameter int WAIT_STATES = 1,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                     Clk,
  input  logic                                     Reset_H,
  input  logic [ADDR_WIDTH-1:0]                    Address,
  input  logic                                     SRamSelect_H,
  input  logic                                     AS_L,
  input  logic                                     UDS_L,
  input  logic                                     LDS_L,
  input  logic                                     RW,
  input  logic [DATA_WIDTH-1:0]                    DataIn,
  output logic [DATA_WIDTH-1:0]                    DataOut,
  output logic                                     Dtack_L,
  output logic [NUM_BLOCKS-1:0]                    Block_H,
  output logic [ADDR_WIDTH-$clog2(NUM_BLOCKS)-1:0] SRamAddress,
  output logic                                     SRamCE_L,
  output logic                                     SRamOE_L,
  output logic                                     SRamWE_L,
  output logic [1:0]                               SRamByteEn_L,
  input  logic [DATA_WIDTH-1:0]                    SRamDataIn,
  output logic [DATA_WIDTH-1:0]                    SRamDataOut,
  output logic                                     SRamDataOutEn_H
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int SA_W  = ADDR_WIDTH - IDX_W;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SA_W-1:0]       addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [1:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  req;
  logic                  active;
  logic [NUM_BLOCKS-1:0] onehot;

  assign req = SRamSelect_H & ~AS_L & (~UDS_L | ~LDS_L);

  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b1;
      be_q    <= '1;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = Address[ADDR_WIDTH-1 -: IDX_W];
          addr_d  = Address[SA_W-1:0];
          rw_d    = RW;
          be_d    = {UDS_L, LDS_L};
          wdata_d = DataIn;
        end
      end
      ACCESS: begin
        // A withdrawn address strobe wins over a completing count: abort without ack.
        if (AS_L) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          if (rw_q) rdata_d = SRamDataIn;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (AS_L) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    onehot        = '0;
    onehot[idx_q] = 1'b1;
  end

  assign active          = (state_q != IDLE);
  assign Block_H         = active ? onehot : '0;
  assign SRamCE_L        = ~active;
  assign SRamOE_L        = ~((state_q == ACCESS) & rw_q);
  assign SRamWE_L        = ~((state_q == ACCESS) & ~rw_q);
  assign SRamDataOutEn_H = active & ~rw_q;
  assign SRamByteEn_L    = active ? be_q : 2'b11;
  assign Dtack_L         = (state_q != ACK);
  assign SRamAddress     = addr_q;
  assign SRamDataOut     = wdata_q;
  assign DataOut         = rdata_q;

endmodule

// File: tb/tb_sram_block_controller.sv
// Scoreboard bench for sram_block_controller: three instances (default, 8 blocks/0 wait,
// 3 wait) share the CPU bus; only the instance whose SRamSelect_H is raised should respond.
module tb_sram_block_controller;

  logic        Clk = 1'b0;
  logic        Reset_H = 1'b1;
  logic [16:0] Address = '0;
  logic        AS_L = 1'b1, UDS_L = 1'b1, LDS_L = 1'b1, RW = 1'b1;
  logic [15:0] DataIn = '0, SRamDataIn = '0;
  logic [2:0]  sel = '0;

  logic [15:0] dout [3];
  logic [15:0] sdo [3];
  logic        dtk [3], ce [3], oe [3], we [3], oen [3];
  logic [1:0]  be [3];
  logic [7:0]  blk [3];
  logic [14:0] sa [3];
  logic [3:0]  blk0, blk2;
  logic [7:0]  blk1;
  logic [14:0] sa0, sa2;
  logic [13:0] sa1;

  assign blk[0] = {4'b0, blk0};
  assign blk[1] = blk1;
  assign blk[2] = {4'b0, blk2};
  assign sa[0]  = sa0;
  assign sa[1]  = {1'b0, sa1};
  assign sa[2]  = sa2;

  always #5 Clk = ~Clk;

  sram_block_controller u_dut0 (
    .Clk(Clk), .Reset_H(Reset_H), .Address(Address), .SRamSelect_H(sel[0]), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .DataIn(DataIn), .DataOut(dout[0]), .Dtack_L(dtk[0]),
    .Block_H(blk0), .SRamAddress(sa0), .SRamCE_L(ce[0]), .SRamOE_L(oe[0]), .SRamWE_L(we[0]),
    .SRamByteEn_L(be[0]), .SRamDataIn(SRamDataIn), .SRamDataOut(sdo[0]), .SRamDataOutEn_H(oen[0]));

  sram_block_controller #(.NUM_BLOCKS(8), .WAIT_STATES(0)) u_dut1 (
    .Clk(Clk), .Reset_H(Reset_H), .Address(Address), .SRamSelect_H(sel[1]), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .DataIn(DataIn), .DataOut(dout[1]), .Dtack_L(dtk[1]),
    .Block_H(blk1), .SRamAddress(sa1), .SRamCE_L(ce[1]), .SRamOE_L(oe[1]), .SRamWE_L(we[1]),
    .SRamByteEn_L(be[1]), .SRamDataIn(SRamDataIn), .SRamDataOut(sdo[1]), .SRamDataOutEn_H(oen[1]));

  sram_block_controller #(.WAIT_STATES(3)) u_dut2 (
    .Clk(Clk), .Reset_H(Reset_H), .Address(Address), .SRamSelect_H(sel[2]), .AS_L(AS_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW), .DataIn(DataIn), .DataOut(dout[2]), .Dtack_L(dtk[2]),
    .Block_H(blk2), .SRamAddress(sa2), .SRamCE_L(ce[2]), .SRamOE_L(oe[2]), .SRamWE_L(we[2]),
    .SRamByteEn_L(be[2]), .SRamDataIn(SRamDataIn), .SRamDataOut(sdo[2]), .SRamDataOutEn_H(oen[2]));

  typedef struct {
    int          dut;
    logic [7:0]  blk;
    logic [14:0] sa;
    logic [1:0]  be;
    logic        rw;
    logic [15:0] data;
    int          k;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   npass = 0;
  int   ntotal = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every falling Dtack_L must match the oldest outstanding expectation.
  initial begin
    logic prev [3];
    exp_t e;
    for (int d = 0; d < 3; d++) prev[d] = 1'b1;
    forever begin
      @(negedge Clk);
      for (int d = 0; d < 3; d++) begin
        if (dtk[d] === 1'b0 && prev[d] === 1'b1) begin
          if (q.size() == 0) begin
            ntotal++;
            $display("FAIL unexpected_dtack: dut %0d acknowledged with no cycle outstanding", d);
          end else begin
            e = q.pop_front();
            check("ack_dut", 32'(d), 32'(e.dut));
            check("ack_latency", 32'(cyc - e.k), 32'(e.lat));
            check("ack_block", 32'(blk[d]), 32'(e.blk));
            check("ack_sramaddr", 32'(sa[d]), 32'(e.sa));
            check("ack_byteen", 32'(be[d]), 32'(e.be));
            if (e.rw) check("ack_dataout", 32'(dout[d]), 32'(e.data));
            else      check("ack_sramdataout", 32'(sdo[d]), 32'(e.data));
          end
        end
        prev[d] = dtk[d];
      end
    end
  end

  task automatic bus_cycle(input int d, input logic [16:0] a, input logic uds, input logic lds,
                           input logic rw, input logic [15:0] wd, input logic [15:0] rd,
                           input logic [7:0] eblk, input logic [14:0] esa, input int ws);
    exp_t e;
    int   n;
    @(negedge Clk);
    Address = a; sel = '0; sel[d] = 1'b1; AS_L = 1'b0;
    UDS_L = uds; LDS_L = lds; RW = rw; DataIn = wd; SRamDataIn = rd;
    e.dut = d; e.blk = eblk; e.sa = esa; e.be = {uds, lds}; e.rw = rw;
    e.data = rw ? rd : wd; e.k = cyc + 1; e.lat = ws + 1;
    q.push_back(e);
    @(negedge Clk);
    sel = '0;   // late select changes must not disturb the latched cycle
    check("access_ce", 32'(ce[d]), 32'd0);
    check("access_oe", 32'(oe[d]), 32'(!rw));
    check("access_we", 32'(we[d]), 32'(rw));
    check("access_oen", 32'(oen[d]), 32'(!rw));
    check("access_block", 32'(blk[d]), 32'(eblk));
    n = 0;
    while (dtk[d] !== 1'b0 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 40) begin
      ntotal++;
      $display("FAIL dtack_timeout: dut %0d no acknowledge within 40 cycles", d);
    end else begin
      check("ack_oe_released", 32'(oe[d]), 32'd1);
      check("ack_we_released", 32'(we[d]), 32'd1);
      check("ack_ce_held", 32'(ce[d]), 32'd0);
      check("ack_oen_hold", 32'(oen[d]), 32'(!rw));
    end
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    @(negedge Clk);
    check("release_dtack", 32'(dtk[d]), 32'd1);
    check("release_ce", 32'(ce[d]), 32'd1);
    check("release_block", 32'(blk[d]), 32'd0);
    check("release_oen", 32'(oen[d]), 32'd0);
    check("release_byteen", 32'(be[d]), 32'd3);
  endtask

  initial begin
    logic [16:0] sweep [4];
    sweep[0] = 17'h00000; sweep[1] = 17'h08000; sweep[2] = 17'h10000; sweep[3] = 17'h18000;

    repeat (2) @(negedge Clk);
    check("reset_block", 32'(blk[0]), 32'd0);
    check("reset_dtack", 32'(dtk[0]), 32'd1);
    check("reset_strobes", 32'({ce[0], oe[0], we[0], be[0]}), 32'h1F);
    check("reset_oen", 32'(oen[0]), 32'd0);
    check("reset_data", 32'({dout[0], sdo[0]}), 32'd0);
    check("reset_sramaddr", 32'(sa[0]), 32'd0);
    Reset_H = 1'b0;

    bus_cycle(0, 17'h08000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 8'h02, 15'h0000, 1);
    bus_cycle(0, 17'h1FFFF, 1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0000, 8'h08, 15'h7FFF, 1);
    bus_cycle(0, 17'h04321, 1'b0, 1'b1, 1'b0, 16'hC3C3, 16'h0000, 8'h01, 15'h4321, 1);
    bus_cycle(0, 17'h00123, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1111, 8'h01, 15'h0123, 1);
    bus_cycle(0, 17'h0A000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h2222, 8'h02, 15'h2000, 1);
    bus_cycle(0, 17'h10004, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h4444, 8'h04, 15'h0004, 1);
    bus_cycle(0, 17'h18000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h8888, 8'h08, 15'h0000, 1);

    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Address = sweep[i]; sel = '0; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; RW = 1'b1;
      repeat (3) @(negedge Clk);
      check("nosel_block", 32'(blk[0]), 32'd0);
      check("nosel_dtack", 32'({dtk[0], dtk[1], dtk[2]}), 32'd7);
      AS_L = 1'b1;
    end

    bus_cycle(1, 17'h0C000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h7E57, 8'h08, 15'h0000, 0);
    bus_cycle(1, 17'h1C005, 1'b0, 1'b1, 1'b0, 16'hA500, 16'h0000, 8'h80, 15'h0005, 0);
    bus_cycle(2, 17'h10010, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 8'h04, 15'h0010, 3);

    @(negedge Clk);
    Address = 17'h08020; sel = 3'b100; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; RW = 1'b1;
    SRamDataIn = 16'hDEAD;
    @(negedge Clk);
    check("abort_in_access", 32'(ce[2]), 32'd0);
    AS_L = 1'b1; sel = '0;
    @(negedge Clk);
    check("abort_ce", 32'(ce[2]), 32'd1);
    check("abort_block", 32'(blk[2]), 32'd0);
    check("abort_oe", 32'(oe[2]), 32'd1);
    repeat (6) @(negedge Clk);
    check("abort_no_dtack", 32'(dtk[2]), 32'd1);
    check("abort_dataout", 32'(dout[2]), 32'h1234);

    @(negedge Clk);
    Address = 17'h08010; sel = 3'b001; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0; RW = 1'b0;
    DataIn = 16'hFFFF;
    @(negedge Clk);
    check("pre_reset_we", 32'(we[0]), 32'd0);
    Reset_H = 1'b1;
    #1;
    check("reset_mid_we", 32'(we[0]), 32'd1);
    check("reset_mid_block", 32'(blk[0]), 32'd0);
    check("reset_mid_dtack", 32'(dtk[0]), 32'd1);
    @(negedge Clk);
    Reset_H = 1'b0; AS_L = 1'b1; sel = '0;
    @(negedge Clk);
    check("post_reset_ce", 32'(ce[0]), 32'd1);
    bus_cycle(0, 17'h08002, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, 8'h02, 15'h0002, 1);

    repeat (3) @(negedge Clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
